lab1_imul_dot_accum: RTL and testbench

LAB1_IMUL_DOT_ACCUM -- requirements
Module: lab1_imul_dot_accum

---
 rtl/lab1_imul_dot_pkg.sv | 26 ++
 rtl/lab1_imul_dot_acc_reg.sv | 49 ++++
 rtl/lab1_imul_dot_accum.sv | 101 ++++++++++
 tb/tb_lab1_imul_dot_accum.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_imul_dot_pkg.sv
// Shared definitions for the dot-product accumulator slice.
//   state_t          : accumulator FSM states (IDLE, ACCUM, DONE)
//   P_NBITS_DEFAULT  : default product/sum width
//   P_LEN_NBITS_DEFAULT : default vector-length field width
//   state_char()     : one-letter state tag for line tracing
package lab1_imul_dot_pkg;

  localparam int unsigned P_NBITS_DEFAULT     = 32;
  localparam int unsigned P_LEN_NBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] state_char(input state_t s);
    case (s)
      IDLE:    return "I";
      ACCUM:   return "A";
      DONE:    return "D";
      default: return "?";
    endcase
  endfunction

endpackage

// File: rtl/lab1_imul_dot_acc_reg.sv
// Adder plus sum register for the dot-product accumulator.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (sum -> 0)
//   en         : add in_msg into the sum this cycle
//   clr        : clear the sum to 0 (takes priority over en)
//   in_msg     : value to accumulate
//   out_msg    : registered sum
// Macro LAB1_IMUL_DOT_ACCUM_SAT_EN: when defined the add saturates at
// all-ones (sticky until clr); otherwise it wraps modulo 2^p_nbits.
module lab1_imul_dot_acc_reg
  import lab1_imul_dot_pkg::*;
#(
  parameter int unsigned p_nbits = P_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [p_nbits-1:0] in_msg,
  output logic [p_nbits-1:0] out_msg
);

  logic [p_nbits-1:0] sum_q;
  logic [p_nbits-1:0] sum_nxt;

`ifdef LAB1_IMUL_DOT_ACCUM_SAT_EN
  logic carry;

  // Once clamped at all-ones, any further add either carries or adds 0,
  // so the saturated value stays put without an extra sticky flag.
  always_comb begin
    {carry, sum_nxt} = {1'b0, sum_q} + {1'b0, in_msg};
    if (carry) sum_nxt = '1;
  end
`else
  always_comb begin
    sum_nxt = sum_q + in_msg;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sum_q <= '0;
    else if (clr) sum_q <= '0;
    else if (en)  sum_q <= sum_nxt;
  end

  assign out_msg = sum_q;

endmodule

// File: rtl/lab1_imul_dot_accum.sv
// Dot-product accumulator: accepts a length N on the cfg channel, sums N
// products arriving on the in channel (from a multiplier response port),
// then presents the sum on the out channel.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cfg_val/rdy/msg   : vector length request (rdy only in IDLE)
//   in_val/rdy/msg    : product stream (rdy only in ACCUM)
//   out_val/rdy/msg   : accumulated sum (val only in DONE); out_msg always
//                       shows the registered sum
// Macro LAB1_IMUL_DOT_ACCUM_SAT_EN: saturating accumulate (see acc_reg).
module lab1_imul_dot_accum
  import lab1_imul_dot_pkg::*;
#(
  parameter int unsigned p_nbits     = P_NBITS_DEFAULT,
  parameter int unsigned p_len_nbits = P_LEN_NBITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [p_len_nbits-1:0] cfg_msg,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_nbits-1:0]     in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_nbits-1:0]     out_msg
);

  state_t                 state_q;
  state_t                 state_nxt;
  logic [p_len_nbits-1:0] count_q;
  logic                   cfg_xfer;
  logic                   in_xfer;

  assign cfg_xfer = cfg_val & cfg_rdy;
  assign in_xfer  = in_val & in_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cfg_rdy   = 1'b0;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_rdy = 1'b1;
        if (cfg_val) state_nxt = (cfg_msg == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_rdy = 1'b1;
        if (in_val && (count_q == p_len_nbits'(1))) state_nxt = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         count_q <= '0;
    else if (cfg_xfer) count_q <= cfg_msg;
    else if (in_xfer)  count_q <= count_q - p_len_nbits'(1);
  end

  lab1_imul_dot_acc_reg #(
    .p_nbits (p_nbits)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .en      (in_xfer),
    .clr     (cfg_xfer),
    .in_msg  (in_msg),
    .out_msg (out_msg)
  );

`ifndef SYNTHESIS
  // Handshake field: message on transfer, '#' stalled valid, '.' not ready.
  function automatic string hs(input logic v, input logic r, input logic [63:0] m);
    if (v && r) return $sformatf("%0h", m);
    if (v)      return "#";
    if (!r)     return ".";
    return " ";
  endfunction

  function automatic string line_trace();
    return $sformatf("cfg:%s in:%s (%c %0d) out:%s",
                     hs(cfg_val, cfg_rdy, 64'(cfg_msg)),
                     hs(in_val, in_rdy, 64'(in_msg)),
                     state_char(state_q), count_q,
                     hs(out_val, out_rdy, 64'(out_msg)));
  endfunction
`endif

endmodule

// File: tb/tb_lab1_imul_dot_accum.sv
module tb_lab1_imul_dot_accum;

  localparam int unsigned NB = 32;
  localparam int unsigned LB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_val;
  logic          cfg_rdy;
  logic [LB-1:0] cfg_msg;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_msg;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_msg;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] mon_exp;

  lab1_imul_dot_accum #(
    .p_nbits     (NB),
    .p_len_nbits (LB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_val (cfg_val),
    .cfg_rdy (cfg_rdy),
    .cfg_msg (cfg_msg),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out transfer pops and compares the next expected sum.
  always @(negedge clk) begin
    if (!reset && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", out_msg);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_msg", out_msg, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [LB-1:0] n);
    int t = 0;
    while (!cfg_rdy && t < 20) begin
      step();
      t++;
    end
    if (!cfg_rdy) check("cfg_rdy_timeout", 32'(cfg_rdy), 1);
    cfg_val = 1'b1;
    cfg_msg = n;
    step();
    cfg_val = 1'b0;
  endtask

  task automatic send(input logic [NB-1:0] p, input int gap);
    int   t    = 0;
    logic xfer = 1'b0;
    repeat (gap) step();
    in_val = 1'b1;
    in_msg = p;
    while (!xfer && t < 20) begin
      xfer = in_rdy;
      step();
      t++;
    end
    if (!xfer) check("in_rdy_timeout", 32'(in_rdy), 1);
    in_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset   = 1'b1;
    cfg_val = 1'b0;
    cfg_msg = '0;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b1;
    #2;
    check("rst_cfg_rdy", 32'(cfg_rdy), 1);
    check("rst_in_rdy",  32'(in_rdy),  0);
    check("rst_out_val", 32'(out_val), 0);
    check("rst_out_msg", out_msg,      0);
    repeat (2) step();
    reset = 1'b0;
    check("post_rst_cfg_rdy", 32'(cfg_rdy), 1);

    // N=3, 2+3+4 back-to-back
    exp_q.push_back(32'd9);
    do_cfg(3);
    check("t1_in_rdy", 32'(in_rdy), 1);
    send(32'd2, 0);
    send(32'd3, 0);
    send(32'd4, 0);
    check("t1_out_val_rise", 32'(out_val), 1);
    check("t1_out_msg", out_msg, 32'd9);
    step();
    check("t1_out_val_fall", 32'(out_val), 0);
    check("t1_cfg_rdy", 32'(cfg_rdy), 1);

    // N=0 with in_val asserted throughout
    in_val = 1'b1;
    in_msg = 32'd55;
    exp_q.push_back(32'd0);
    do_cfg(0);
    in_val = 1'b1;
    check("t2_out_val", 32'(out_val), 1);
    check("t2_out_msg", out_msg, 32'd0);
    check("t2_in_rdy",  32'(in_rdy), 0);
    step();
    check("t2_back_idle", 32'(cfg_rdy), 1);
    check("t2_out_msg_held", out_msg, 32'd0);
    in_val = 1'b0;

    // Overflow behaviour
`ifdef LAB1_IMUL_DOT_ACCUM_SAT_EN
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
`else
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0006);
`endif
    do_cfg(2);
    send(32'hFFFF_FFFF, 0);
    send(32'h2, 0);
    step();
    do_cfg(3);
    send(32'hFFFF_FFFF, 0);
    send(32'h2, 0);
    send(32'h5, 0);
    step();

    // N=4 with gaps, consumer stalled 5 cycles
    exp_q.push_back(32'd100);
    do_cfg(4);
    send(32'd10, int'($urandom_range(1, 3)));
    send(32'd20, int'($urandom_range(1, 3)));
    send(32'd30, int'($urandom_range(1, 3)));
    out_rdy = 1'b0;
    send(32'd40, int'($urandom_range(1, 3)));
    for (int i = 0; i < 5; i++) begin
      check("t4_out_val", 32'(out_val), 1);
      check("t4_cfg_rdy", 32'(cfg_rdy), 0);
      check("t4_in_rdy",  32'(in_rdy),  0);
      check("t4_out_msg", out_msg, 32'd100);
      step();
    end
    out_rdy = 1'b1;
    step();
    check("t4_release", 32'(cfg_rdy), 1);

    // Ignored val outside the accepting state
    in_val = 1'b1;
    in_msg = 32'd100;
    for (int i = 0; i < 2; i++) begin
      check("t5_idle_in_rdy", 32'(in_rdy), 0);
      step();
    end
    in_val = 1'b0;
    exp_q.push_back(32'd30);
    do_cfg(2);
    cfg_val = 1'b1;
    cfg_msg = 8'd7;
    send(32'd10, 0);
    check("t5_accum_cfg_rdy", 32'(cfg_rdy), 0);
    out_rdy = 1'b0;
    send(32'd20, 0);
    in_val = 1'b1;
    in_msg = 32'd99;
    for (int i = 0; i < 2; i++) begin
      check("t5_done_out_msg", out_msg, 32'd30);
      check("t5_done_in_rdy",  32'(in_rdy), 0);
      check("t5_done_cfg_rdy", 32'(cfg_rdy), 0);
      step();
    end
    cfg_val = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    step();

    // Reset in the middle of accumulation
    exp_q.push_back(32'd999);
    do_cfg(5);
    send(32'd1, 0);
    send(32'd2, 0);
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("t6_rst_cfg_rdy", 32'(cfg_rdy), 1);
    check("t6_rst_in_rdy",  32'(in_rdy),  0);
    check("t6_rst_out_val", 32'(out_val), 0);
    check("t6_rst_out_msg", out_msg,      0);
    step();
    reset = 1'b0;
    exp_q.push_back(32'd7);
    do_cfg(1);
    send(32'd7, 0);
    check("t6_out_val", 32'(out_val), 1);
    step();

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      step();
      t++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
